// File: rtl/zap_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// zap_fetch_queue_if
//   Bundles the fetch-queue data path into one port. Signal names are given
//   from the queue's point of view: i_* flow into the queue, o_* flow out.
//
//   Upstream (I-cache side) : i_pc_ff, i_cpsr_ff_t, i_instruction, i_valid,
//                             i_instr_abort, i_taken, i_pred  -> o_ready
//   Downstream (decode side): i_stall -> o_valid, o_instruction,
//                             o_instr_abort, o_pc_ff, o_pc_plus_8_ff,
//                             o_taken, o_pred, o_count
//
//   Modports:
//     slave  - the queue itself
//     master - whatever drives the queue (cache + decode, or a testbench)
// ---------------------------------------------------------------------------
interface zap_fetch_queue_if #(
  parameter int DEPTH    = 4,
  parameter int PRED_WDT = 33
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Upstream fetch word
  logic [31:0]          i_pc_ff;
  logic                 i_cpsr_ff_t;
  logic [31:0]          i_instruction;
  logic                 i_valid;
  logic                 i_instr_abort;
  logic [1:0]           i_taken;
  logic [PRED_WDT-1:0]  i_pred;
  logic                 o_ready;

  // Downstream head entry
  logic                 i_stall;
  logic                 o_valid;
  logic [31:0]          o_instruction;
  logic                 o_instr_abort;
  logic [31:0]          o_pc_ff;
  logic [31:0]          o_pc_plus_8_ff;
  logic [1:0]           o_taken;
  logic [PRED_WDT-1:0]  o_pred;
  logic [CW-1:0]        o_count;

  modport slave (
    input  i_pc_ff, i_cpsr_ff_t, i_instruction, i_valid, i_instr_abort,
           i_taken, i_pred, i_stall,
    output o_ready, o_valid, o_instruction, o_instr_abort, o_pc_ff,
           o_pc_plus_8_ff, o_taken, o_pred, o_count
  );

  modport master (
    output i_pc_ff, i_cpsr_ff_t, i_instruction, i_valid, i_instr_abort,
           i_taken, i_pred, i_stall,
    input  o_ready, o_valid, o_instruction, o_instr_abort, o_pc_ff,
           o_pc_plus_8_ff, o_taken, o_pred, o_count
  );
endinterface

// File: rtl/zap_fetch_queue.sv
// ---------------------------------------------------------------------------
// zap_fetch_queue
//   DEPTH-entry FIFO between the I-cache and decode. Decouples cache delivery
//   from decode stalls. Each word is transformed as it is enqueued:
//     - Thumb half-word select (i_pc_ff[1] picks the upper half-word)
//     - PC+8 (ARM) / PC+4 (Thumb) generation
//     - abort tagging (cache abort, or breakpoint when enabled)
//   An aborting entry puts the queue to sleep (o_ready=0) until a flush or
//   reset, so it is the last word accepted.
//
// Ports:
//   i_clk                   clock
//   i_reset_n               asynchronous active-low reset
//   i_clear_from_writeback  flush (highest priority)
//   i_clear_from_alu        flush
//   i_clear_from_decode     flush
//   fq                      zap_fetch_queue_if.slave: upstream fetch word +
//                           o_ready, downstream i_stall + head entry/o_count
//
// Build option:
//   ZAP_FETCH_QUEUE_BKPT_EN - when defined, BKPT instructions (ARM and Thumb)
//   are detected at enqueue and tagged as aborts. When undefined they flow
//   through as ordinary instructions.
// ---------------------------------------------------------------------------
module zap_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PRED_WDT = 33
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clear_from_writeback,
  input  logic                i_clear_from_alu,
  input  logic                i_clear_from_decode,
  zap_fetch_queue_if.slave    fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]         instr;
    logic [31:0]         pc;
    logic [31:0]         pc8;
    logic                abort;
    logic [1:0]          taken;
    logic [PRED_WDT-1:0] pred;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_ff;
  logic            sleep_ff;

  logic            flush;
  logic            push;
  logic            pop;
  logic            bkpt_hit;
  logic            enq_abort;
  entry_t          enq;

  // -------------------------------------------------------------------------
  // Enqueue transforms
  // -------------------------------------------------------------------------
  function automatic logic [31:0] sel_instr(input logic [31:0] word,
                                            input logic        upper);
    return upper ? {16'h0000, word[31:16]} : word;
  endfunction

  // Wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_adv(input logic [31:0] pc,
                                         input logic        thumb);
    return pc + (thumb ? 32'd4 : 32'd8);
  endfunction

`ifdef ZAP_FETCH_QUEUE_BKPT_EN
  // ARM : 1110_0001_0010_xxxx_xxxx_xxxx_0111_xxxx
  // Thumb: 1011_1110_xxxx_xxxx on the selected half-word
  function automatic logic is_bkpt(input logic [31:0] word,
                                   input logic        upper,
                                   input logic        thumb);
    logic [15:0] half;
    half = upper ? word[31:16] : word[15:0];
    if (thumb) return (half[15:8] == 8'hBE);
    else       return (word[31:20] == 12'hE12) && (word[7:4] == 4'h7);
  endfunction

  assign bkpt_hit = is_bkpt(fq.i_instruction, fq.i_pc_ff[1], fq.i_cpsr_ff_t);
`else
  assign bkpt_hit = 1'b0;
`endif

  assign enq_abort = fq.i_instr_abort | bkpt_hit;

  always_comb begin
    enq       = '0;
    enq.instr = sel_instr(fq.i_instruction, fq.i_pc_ff[1]);
    enq.pc    = fq.i_pc_ff;
    enq.pc8   = pc_adv(fq.i_pc_ff, fq.i_cpsr_ff_t);
    enq.abort = enq_abort;
    enq.taken = fq.i_taken;
    enq.pred  = fq.i_pred;
  end

  // -------------------------------------------------------------------------
  // Handshake. o_ready depends on registers only, never on i_stall, so a
  // pop in a full cycle does not allow a push until the next cycle.
  // -------------------------------------------------------------------------
  assign flush      = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
  assign fq.o_ready = (count_ff < FULL) && !sleep_ff;
  assign fq.o_valid = (count_ff != '0);
  assign push       = fq.i_valid && fq.o_ready;
  assign pop        = fq.o_valid && !fq.i_stall;

  // -------------------------------------------------------------------------
  // Storage, pointers, occupancy, sleep. Flush wins over push/pop/stall and
  // leaves storage contents untouched.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_ff <= '0;
      sleep_ff <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_ff <= '0;
      sleep_ff <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enq;
        wr_ptr      <= wr_ptr + AW'(1);
        if (enq_abort) sleep_ff <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_ff <= count_ff + CW'(1);
        2'b01:   count_ff <= count_ff - CW'(1);
        default: count_ff <= count_ff;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Head entry
  // -------------------------------------------------------------------------
  assign fq.o_instruction  = mem[rd_ptr].instr;
  assign fq.o_instr_abort  = mem[rd_ptr].abort;
  assign fq.o_pc_ff        = mem[rd_ptr].pc;
  assign fq.o_pc_plus_8_ff = mem[rd_ptr].pc8;
  assign fq.o_taken        = mem[rd_ptr].taken;
  assign fq.o_pred         = mem[rd_ptr].pred;
  assign fq.o_count        = count_ff;

endmodule

// File: tb/tb_zap_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_zap_fetch_queue
//   Directed bench for zap_fetch_queue (DEPTH=4, PRED_WDT=33). Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_zap_fetch_queue;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr_wb  = 1'b0;
  logic clr_alu = 1'b0;
  logic clr_dec = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zap_fetch_queue_if #(.DEPTH(4), .PRED_WDT(33)) fq ();

  zap_fetch_queue #(.DEPTH(4), .PRED_WDT(33)) dut (
    .i_clk                  (clk),
    .i_reset_n              (rst_n),
    .i_clear_from_writeback (clr_wb),
    .i_clear_from_alu       (clr_alu),
    .i_clear_from_decode    (clr_dec),
    .fq                     (fq.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic t, input logic ab);
    fq.i_valid       = v;
    fq.i_pc_ff       = pc;
    fq.i_instruction = instr;
    fq.i_cpsr_ff_t   = t;
    fq.i_instr_abort = ab;
  endtask

  initial begin
    fq.i_taken = 2'b00;
    fq.i_pred  = '0;
    fq.i_stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset state (asynchronous, before any edge)
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", fq.o_valid, 0);
    chk("rst_ready", fq.o_ready, 1);
    chk("rst_count", fq.o_count, 0);
    chk("rst_instr", fq.o_instruction, 0);
    chk("rst_pc8",   fq.o_pc_plus_8_ff, 0);
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    step();

    // Fill under stall
    fq.i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4*i), 32'hA000_0000 | 32'(4*i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("fill_ready", fq.o_ready, 0);
    chk("fill_count", fq.o_count, 4);
    chk("fill_valid", fq.o_valid, 1);
    chk("fill_instr", fq.o_instruction, 64'hA000_0000);
    chk("fill_pc",    fq.o_pc_ff, 0);
    chk("fill_pc8",   fq.o_pc_plus_8_ff, 8);
    // Push attempt while full is ignored; head held by stall
    drive(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    chk("full_count", fq.o_count, 4);
    chk("stall_pc",   fq.o_pc_ff, 0);

    // Drain two, then concurrent push/pop at count 2
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    fq.i_stall = 1'b0;
    step(); step();
    chk("drain_count", fq.o_count, 2);
    chk("drain_pc",    fq.o_pc_ff, 8);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h10 + 32'(4*k), 32'hA000_0000 | (32'h10 + 32'(4*k)), 1'b0, 1'b0);
      step();
      chk("conc_count", fq.o_count, 2);
      chk("conc_valid", fq.o_valid, 1);
      chk("conc_pc",    fq.o_pc_ff, 32'hC + 32'(4*k));
      chk("conc_instr", fq.o_instruction, 32'hA000_000C + 32'(4*k));
    end

    // Flush vs stall vs push at count 3
    fq.i_stall = 1'b1;
    drive(1'b1, 32'h100, 32'h1111_1111, 1'b0, 1'b0);
    step();
    chk("pre_flush_count", fq.o_count, 3);
    drive(1'b1, 32'h200, 32'h2222_2222, 1'b0, 1'b0);
    clr_dec = 1'b1;
    step();
    clr_dec = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_valid", fq.o_valid, 0);
    chk("flush_count", fq.o_count, 0);
    chk("flush_ready", fq.o_ready, 1);
    fq.i_stall = 1'b0;
    step();
    chk("flush_nopush", fq.o_count, 0);

    // Thumb select at an odd half-word
    fq.i_stall = 1'b1;
    drive(1'b1, 32'h102, 32'hBE01_4770, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("thumb_count", fq.o_count, 1);
    chk("thumb_instr", fq.o_instruction, 32'h0000_BE01);
    chk("thumb_pc",    fq.o_pc_ff, 32'h102);
    chk("thumb_pc8",   fq.o_pc_plus_8_ff, 32'h106);
`ifdef ZAP_FETCH_QUEUE_BKPT_EN
    chk("thumb_bkpt_abort", fq.o_instr_abort, 1);
    chk("thumb_bkpt_ready", fq.o_ready, 0);
`else
    chk("thumb_abort", fq.o_instr_abort, 0);
    chk("thumb_ready", fq.o_ready, 1);
`endif
    clr_wb = 1'b1;
    step();
    clr_wb = 1'b0;
    chk("wb_flush_count", fq.o_count, 0);
    chk("wb_flush_ready", fq.o_ready, 1);
    // Thumb at even half-word keeps the whole word, PC+4 wraps modulo 2^32
    drive(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("thumb_lo_instr", fq.o_instruction, 32'h1234_5678);
    chk("thumb_wrap_pc8", fq.o_pc_plus_8_ff, 32'h0000_0000);
    clr_alu = 1'b1;
    step();
    clr_alu = 1'b0;

    // Abort sleep
    fq.i_taken = 2'b10;
    fq.i_pred  = 33'h1_0000_0040;
    drive(1'b1, 32'h1C, 32'hE1A0_0000, 1'b0, 1'b0);
    step();
    fq.i_taken = 2'b01;
    fq.i_pred  = 33'h0_0000_0080;
    drive(1'b1, 32'h20, 32'hE1A0_1111, 1'b0, 1'b1);
    step();
    chk("sleep_ready", fq.o_ready, 0);
    drive(1'b1, 32'h24, 32'hE1A0_2222, 1'b0, 1'b0);
    step();
    chk("sleep_count", fq.o_count, 2);
    chk("sleep_head_pc",    fq.o_pc_ff, 32'h1C);
    chk("sleep_head_abort", fq.o_instr_abort, 0);
    chk("sleep_head_taken", fq.o_taken, 2'b10);
    chk("sleep_head_pred",  fq.o_pred, 33'h1_0000_0040);
    fq.i_stall = 1'b0;
    step();
    chk("abort_pc",    fq.o_pc_ff, 32'h20);
    chk("abort_bit",   fq.o_instr_abort, 1);
    chk("abort_taken", fq.o_taken, 2'b01);
    chk("abort_pred",  fq.o_pred, 33'h0_0000_0080);
    step();
    chk("drained_valid", fq.o_valid, 0);
    chk("drained_ready", fq.o_ready, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    clr_alu = 1'b1;
    step();
    clr_alu = 1'b0;
    chk("wake_count", fq.o_count, 0);
    chk("wake_ready", fq.o_ready, 1);

    // Asynchronous reset mid-stream
    fq.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4*i), 32'h3300_0000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_count", fq.o_count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", fq.o_valid, 0);
    chk("arst_count", fq.o_count, 0);
    chk("arst_ready", fq.o_ready, 1);
    chk("arst_pc",    fq.o_pc_ff, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
